// File: rtl/fft_ctrl_pkg.sv
// Shared types and defaults for the 16-point FFT frame sequencer.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int N_POINTS_DEF = 16;
  localparam int CNT_W_DEF    = 4;
  localparam int TIMEOUT_DEF  = 255;
  localparam int FRAMES_W     = 8;

  // Counter width able to hold the value t.
  function automatic int wd_width(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/fft_ctrl_watchdog.sv
// Cycle counter bounding how long the sequencer waits for the FFT core.
module fft_ctrl_watchdog
  import fft_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int WD_W    = wd_width(TIMEOUT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WD_W-1:0] cnt_q, cnt_d;

  // The count excludes the current cycle, so the TIMEOUT-th enabled cycle sees TIMEOUT-1.
  assign expired = en && (cnt_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: fills the deserializer, launches the FFT core, waits with a
// watchdog, then steps the output bin selector under sink backpressure.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int N_POINTS = N_POINTS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                shift_en,
  output logic [CNT_W-1:0]    in_idx,
  output logic                core_start,
  input  logic                core_done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    out_sel,
  output logic                out_last,
  output logic [FRAMES_W-1:0] frames_done,
  output logic                err,
  input  logic                clr_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_POINTS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    in_idx_q, in_idx_d;
  logic [CNT_W-1:0]    out_sel_q, out_sel_d;
  logic [FRAMES_W-1:0] frames_q, frames_d;
  logic                err_q, err_d;
  logic                err_set;
  logic                wd_clr, wd_en, wd_expired;

  assign in_ready    = (state_q == ST_FILL);
  assign core_start  = (state_q == ST_START);
  assign out_valid   = (state_q == ST_DRAIN);
  assign out_last    = out_valid && (out_sel_q == LAST_IDX);
  assign shift_en    = in_valid && in_ready;
  assign in_idx      = in_idx_q;
  assign out_sel     = out_sel_q;
  assign frames_done = frames_q;
  assign err         = err_q;

  // Watchdog only runs in WAIT and is held at zero everywhere else.
  assign wd_en  = (state_q == ST_WAIT);
  assign wd_clr = !wd_en;

  fft_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    out_sel_d = out_sel_q;
    frames_d  = frames_q;
    err_set   = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (shift_en) begin
          if (in_idx_q == LAST_IDX) begin
            in_idx_d = '0;
            state_d  = ST_START;
          end else begin
            in_idx_d = in_idx_q + CNT_W'(1);
          end
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion beats the watchdog when both land in the same cycle.
        if (core_done) begin
          state_d   = ST_DRAIN;
          out_sel_d = '0;
        end else if (wd_expired) begin
          err_set = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (out_sel_q == LAST_IDX) begin
            out_sel_d = '0;
            frames_d  = frames_q + FRAMES_W'(1);
            state_d   = ST_FILL;
          end else begin
            out_sel_d = out_sel_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    if (core_done && (state_q != ST_WAIT)) begin
      err_set = 1'b1;
    end

    if (err_set) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FILL;
      in_idx_q  <= '0;
      out_sel_q <= '0;
      frames_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_sel_q <= out_sel_d;
      frames_q  <= frames_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed and randomized bench for fft_frame_ctrl with a transaction-level
// expectation of sample indices, bin order, frame counting and error behaviour.
module tb_fft_frame_ctrl;

  localparam int N  = 16;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       shift_en;
  logic [3:0] in_idx;
  logic       core_start;
  logic       core_done = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_sel;
  logic       out_last;
  logic [7:0] frames_done;
  logic       err;
  logic       clr_err = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int frames = 0;

  fft_frame_ctrl #(
    .N_POINTS (N),
    .CNT_W    (4),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .shift_en    (shift_en),
    .in_idx      (in_idx),
    .core_start  (core_start),
    .core_done   (core_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sel     (out_sel),
    .out_last    (out_last),
    .frames_done (frames_done),
    .err         (err),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer samples until index 'stop' is reached; each accepted sample must carry the next index.
  task automatic fill(input int start, input int stop, input int vprob, output int pulses);
    int idx;
    int c;
    logic v;
    idx = start;
    pulses = 0;
    c = 0;
    while (idx < stop && c < 4000) begin
      in_valid = ($urandom_range(0, 99) < vprob);
      v = in_valid;
      #1;
      chk("fill_in_ready", in_ready, 1);
      chk("fill_in_idx", in_idx, idx);
      chk("fill_shift_en", shift_en, v);
      chk("fill_no_start", core_start, 0);
      chk("fill_no_out", out_valid, 0);
      step();
      if (v) begin
        idx++;
        pulses++;
      end
      c++;
    end
    in_valid = 1'b0;
    chk("fill_reached", idx, stop);
  endtask

  // Cycle after the last sample: launch pulse, sample input ignored.
  task automatic start_cycle();
    in_valid = 1'b1;
    #1;
    chk("start_pulse", core_start, 1);
    chk("start_not_ready", in_ready, 0);
    chk("start_shift_ignored", shift_en, 0);
    chk("start_no_out", out_valid, 0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic launch_and_drain(input int lat, input int rprob);
    int bin;
    int c;
    logic r;
    logic done;
    start_cycle();
    for (int k = 0; k < lat; k++) begin
      #1;
      chk("wait_no_out", out_valid, 0);
      chk("wait_not_ready", in_ready, 0);
      chk("wait_single_start", core_start, 0);
      step();
    end
    core_done = 1'b1;
    #1;
    chk("wait_done_no_out", out_valid, 0);
    step();
    core_done = 1'b0;
    bin = 0;
    done = 1'b0;
    c = 0;
    while (!done && c < 4000) begin
      out_ready = ($urandom_range(0, 99) < rprob);
      r = out_ready;
      #1;
      chk("drain_valid", out_valid, 1);
      chk("drain_sel", out_sel, bin);
      chk("drain_last", out_last, (bin == N - 1));
      chk("drain_not_ready", in_ready, 0);
      step();
      if (r) begin
        if (bin == N - 1) done = 1'b1;
        else bin++;
      end
      c++;
    end
    out_ready = 1'b0;
    chk("drain_complete", done, 1);
    frames++;
    #1;
    chk("frame_count", frames_done, frames % 256);
    chk("frame_back_to_fill", in_ready, 1);
    chk("frame_idx_zero", in_idx, 0);
    chk("frame_sel_zero", out_sel, 0);
    chk("frame_no_out", out_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_shift_en"}, shift_en, 0);
    chk({tag, "_in_idx"}, in_idx, 0);
    chk({tag, "_out_sel"}, out_sel, 0);
    chk({tag, "_frames_done"}, frames_done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    int p;
    int fd_before;

    // Power-on reset
    #2;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;

    // Back-to-back frame, core answers 8 cycles after launch, sink always ready
    fill(0, N, 100, p);
    chk("t1_pulses", p, 16);
    launch_and_drain(7, 100);
    chk("t1_err", err, 0);

    // Random source gaps, 50% sink backpressure, random core latency
    for (int f = 0; f < 4; f++) begin
      fill(0, N, 60, p);
      chk("rnd_pulses", p, 16);
      launch_and_drain($urandom_range(0, 20), 50);
      chk("rnd_err", err, 0);
    end

    // Core never completes: watchdog abort
    fd_before = frames;
    fill(0, N, 100, p);
    start_cycle();
    for (int k = 1; k <= TO; k++) begin
      #1;
      chk("to_still_waiting", in_ready, 0);
      chk("to_no_out", out_valid, 0);
      chk("to_err_low", err, 0);
      step();
    end
    #1;
    chk("to_back_to_fill", in_ready, 1);
    chk("to_err_set", err, 1);
    chk("to_frames_same", frames_done, fd_before % 256);
    chk("to_idx_zero", in_idx, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    #1;
    chk("to_err_cleared", err, 0);

    // Spurious completion during fill
    fill(0, 5, 100, p);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    #1;
    chk("sp_err_set", err, 1);
    chk("sp_idx_kept", in_idx, 5);
    chk("sp_still_fill", in_ready, 1);
    clr_err = 1'b1;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    #1;
    chk("sp_set_wins", err, 1);
    step();
    clr_err = 1'b0;
    #1;
    chk("sp_err_cleared", err, 0);
    chk("sp_idx_still", in_idx, 5);
    fill(5, N, 100, p);
    chk("sp_pulses", p, 11);
    launch_and_drain(3, 100);
    chk("sp_frame_err", err, 0);

    // Reset in the middle of a fill
    fill(0, 7, 100, p);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    frames = 0;
    step();
    reset = 1'b1;
    #1;
    fill(0, N, 100, p);
    chk("midrst_pulses", p, 16);
    launch_and_drain(5, 100);

    // Remaining 255 frames take the counter through 255 back to 0
    while (frames < 256) begin
      fill(0, N, 85, p);
      launch_and_drain($urandom_range(0, 4), 75);
      chk("wrap_err", err, 0);
    end
    #1;
    chk("wrap_zero", frames_done, 0);
    chk("wrap_no_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
